// File: rtl/apb_pkg.sv
// Shared APB completer definitions: bus widths, FSM state encoding and the
// address decode used by the register-file slaves on the bridge's APB bus.
package apb_pkg;

    localparam int APB_AW    = 32;
    localparam int APB_DW    = 32;
    localparam int APB_IDX_W = 6;
    localparam logic [APB_DW-1:0] APB_DEFAULT_ID = 32'hA9B0_0001;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_t;

    typedef struct packed {
        logic                 err;
        logic [APB_IDX_W-1:0] idx;
    } apb_decode_t;

    // Compare in 33 bits so base + 4*nRegs can never wrap past 2^32.
    function automatic apb_decode_t apbDecode(
        input logic [APB_AW-1:0] addr,
        input logic              write,
        input logic [APB_AW-1:0] base,
        input int unsigned       nRegs
    );
        apb_decode_t     d;
        logic [APB_AW:0] addrExt;
        logic [APB_AW:0] lo;
        logic [APB_AW:0] hi;
        addrExt = {1'b0, addr};
        lo      = {1'b0, base};
        hi      = lo + (33'(nRegs) << 2);
        d.idx   = APB_IDX_W'((addrExt - lo) >> 2);
        d.err   = (addr[1:0] != 2'b00) || (addrExt < lo) || (addrExt >= hi) ||
                  (write && (d.idx == '0));
        return d;
    endfunction

endpackage

// File: rtl/apb_regfile.sv
// Word-addressed register storage with one write port and one combinational
// read port; index 0 is a constant ID and never holds state.
module apb_regfile
    import apb_pkg::*;
#(
    parameter int                N_REGS   = 16,
    parameter logic [APB_DW-1:0] ID_VALUE = APB_DEFAULT_ID
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_we,
    input  logic [APB_IDX_W-1:0] i_widx,
    input  logic [APB_DW-1:0]    i_wdata,
    input  logic [APB_IDX_W-1:0] i_ridx,
    output logic [APB_DW-1:0]    o_rdata
);

    localparam int                 DEPTH     = 1 << APB_IDX_W;
    localparam logic [APB_IDX_W:0] NREGS_EXT = (APB_IDX_W + 1)'(N_REGS);

    logic [APB_DW-1:0] r_mem [DEPTH];

    // Entries at or above N_REGS are never written and stay at their reset value.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_widx != '0) && ({1'b0, i_widx} < NREGS_EXT)) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    assign o_rdata = (i_ridx == '0) ? ID_VALUE : r_mem[i_ridx];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer backing a small register file: setup-phase latch and decode,
// access phase stretched by WAIT_STATES, error response for bad addresses.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int                SLAVE_IDX   = 0,
    parameter logic [APB_AW-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int                N_REGS      = 16,
    parameter int                WAIT_STATES = 0,
    parameter logic [APB_DW-1:0] ID_VALUE    = APB_DEFAULT_ID
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic [2:0]        psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [APB_AW-1:0] paddr,
    input  logic [APB_DW-1:0] pwdata,
    output logic [APB_DW-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    apb_state_t           r_state;
    logic [3:0]           r_wcnt;
    logic [APB_IDX_W-1:0] r_aIdx;
    logic                 r_aWrite;
    logic [APB_DW-1:0]    r_aWdata;
    logic                 r_aErr;
    logic [APB_DW-1:0]    r_prdata;

    logic                 w_sel;
    logic                 w_setup;
    logic                 w_accessDone;
    logic                 w_we;
    apb_decode_t          w_dec;
    logic [APB_DW-1:0]    w_rdata;

    assign w_sel        = |(psel & (3'b001 << SLAVE_IDX));
    assign w_setup      = w_sel && !penable;
    assign w_accessDone = (r_state == ST_ACCESS) && w_sel && penable && (r_wcnt == 4'd0);
    assign w_we         = w_accessDone && r_aWrite && !r_aErr;
    assign w_dec        = apbDecode(paddr, pwrite, BASE_ADDR, N_REGS);
    assign prdata       = r_prdata;

    apb_regfile #(
        .N_REGS   (N_REGS),
        .ID_VALUE (ID_VALUE)
    ) u_regfile (
        .i_clk   (hclk),
        .i_reset (hreset),
        .i_we    (w_we),
        .i_widx  (r_aIdx),
        .i_wdata (r_aWdata),
        .i_ridx  (w_dec.idx),
        .o_rdata (w_rdata)
    );

    // A setup phase restarts the transfer from either state, discarding any old one.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state  <= ST_IDLE;
            r_wcnt   <= 4'd0;
            r_aIdx   <= '0;
            r_aWrite <= 1'b0;
            r_aWdata <= '0;
            r_aErr   <= 1'b0;
            r_prdata <= '0;
        end else if (w_setup) begin
            r_state  <= ST_ACCESS;
            r_wcnt   <= WAIT_LOAD;
            r_aIdx   <= w_dec.idx;
            r_aWrite <= pwrite;
            r_aWdata <= pwdata;
            r_aErr   <= w_dec.err;
            if (!pwrite) begin
                r_prdata <= w_dec.err ? '0 : w_rdata;
            end
        end else if (r_state == ST_ACCESS) begin
            if (!w_sel || (r_wcnt == 4'd0)) begin
                r_state <= ST_IDLE;
            end else begin
                r_wcnt <= r_wcnt - 4'd1;
            end
        end
    end

    always_comb begin
        pready  = 1'b1;
        pslverr = 1'b0;
        if (r_state == ST_ACCESS) begin
            if (w_sel && penable) begin
                pready  = (r_wcnt == 4'd0);
                pslverr = (r_wcnt == 4'd0) && r_aErr;
            end
        end else if (w_sel && penable) begin
            pslverr = 1'b1;
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: slave A (psel[0], no wait states) and slave B
// (psel[1], three wait states) share one APB bus; a reference model feeds a scoreboard.
module tb_apb_slave_regfile;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] ID   = 32'hA9B0_0001;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        err;
        int          waits;
    } exp_t;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdataA, prdataB;
    logic        preadyA, preadyB;
    logic        pslverrA, pslverrB;

    int          nChecks = 0;
    int          nPass   = 0;
    logic [31:0] model    [2][16];
    logic [31:0] lastRead [2];
    exp_t        sbQueue  [$];

    always #5 hclk = ~hclk;

    apb_slave_regfile #(
        .SLAVE_IDX(0), .BASE_ADDR(BASE), .N_REGS(16), .WAIT_STATES(0), .ID_VALUE(ID)
    ) dutA (
        .hclk(hclk), .hreset(hreset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdataA), .pready(preadyA), .pslverr(pslverrA)
    );

    apb_slave_regfile #(
        .SLAVE_IDX(1), .BASE_ADDR(BASE), .N_REGS(16), .WAIT_STATES(3), .ID_VALUE(ID)
    ) dutB (
        .hclk(hclk), .hreset(hreset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdataB), .pready(preadyB), .pslverr(pslverrB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual === expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic readyOf(input int s);
        return (s == 0) ? preadyA : preadyB;
    endfunction

    function automatic logic errOf(input int s);
        return (s == 0) ? pslverrA : pslverrB;
    endfunction

    function automatic logic [31:0] rdataOf(input int s);
        return (s == 0) ? prdataA : prdataB;
    endfunction

    task automatic clearModel();
        for (int s = 0; s < 2; s++) begin
            lastRead[s] = 32'h0;
            for (int r = 0; r < 16; r++) model[s][r] = 32'h0;
        end
    endtask

    // Reference decode: expected error and the prdata value seen in the access cycle.
    task automatic modelExpect(input int s, input logic wr, input logic [31:0] addr,
                               output logic err, output logic [31:0] rd);
        logic [31:0] off;
        off = addr - BASE;
        err = (addr[1:0] != 2'b00) || (addr < BASE) || (addr >= BASE + 32'd64) ||
              (wr && (addr == BASE));
        if (wr) begin
            rd = lastRead[s];
        end else begin
            rd = err ? 32'h0 : ((off[5:2] == 4'd0) ? ID : model[s][off[5:2]]);
            lastRead[s] = rd;
        end
    endtask

    // One full transfer; entered and left just after a rising edge so calls chain back-to-back.
    task automatic applyStimulus(input int s, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, input string tag);
        exp_t        e;
        exp_t        got;
        logic        err;
        logic [31:0] rd;
        logic [31:0] off;
        int          waits;
        modelExpect(s, wr, addr, err, rd);
        e.tag   = tag;
        e.data  = rd;
        e.err   = err;
        e.waits = (s == 0) ? 0 : 3;
        sbQueue.push_back(e);
        psel    = (s == 0) ? 3'b001 : 3'b010;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        @(posedge hclk);
        #1 penable = 1'b1;
        waits = 0;
        @(negedge hclk);
        while (!readyOf(s) && waits < 40) begin
            waits++;
            @(posedge hclk);
            #1;
            @(negedge hclk);
        end
        got = sbQueue.pop_front();
        checkOutput({got.tag, "/ready"}, 32'(readyOf(s)), 32'd1);
        checkOutput({got.tag, "/waits"}, 32'(waits), 32'(got.waits));
        checkOutput({got.tag, "/pslverr"}, 32'(errOf(s)), 32'(got.err));
        checkOutput({got.tag, "/prdata"}, rdataOf(s), got.data);
        @(posedge hclk);
        off = addr - BASE;
        if (wr && !got.err) model[s][off[5:2]] = data;
        #1;
        psel    = 3'b000;
        penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clearModel();
        hreset  = 1'b1;
        psel    = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'h0;
        pwdata  = 32'h0;
        repeat (2) @(posedge hclk);
        #1 hreset = 1'b0;
        @(negedge hclk);
        checkOutput("resetA/ready", 32'(preadyA), 32'd1);
        checkOutput("resetA/pslverr", 32'(pslverrA), 32'd0);
        checkOutput("resetA/prdata", prdataA, 32'h0);
        checkOutput("resetB/prdata", prdataB, 32'h0);
        @(posedge hclk);
        #1;

        $display("[TB] write/read and ID register on slave A");
        applyStimulus(0, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, "wrA4");
        applyStimulus(0, 1'b0, 32'h8000_0004, 32'h0, "rdA4");
        applyStimulus(0, 1'b0, 32'h8000_0000, 32'h0, "rdId");
        applyStimulus(0, 1'b1, 32'h8000_0000, 32'h0000_1234, "wrId");
        applyStimulus(0, 1'b0, 32'h8000_0000, 32'h0, "rdIdAgain");

        $display("[TB] decode errors on slave A");
        applyStimulus(0, 1'b0, 32'h8000_0040, 32'h0, "rdPastEnd");
        applyStimulus(0, 1'b0, 32'h8000_0006, 32'h0, "rdUnaligned");
        applyStimulus(0, 1'b1, 32'h7FFF_FFFC, 32'hCAFE_F00D, "wrBelowBase");
        applyStimulus(0, 1'b0, 32'h8000_003C, 32'h0, "rdLastReg");
        applyStimulus(0, 1'b0, 32'h8000_0004, 32'h0, "rdA4Kept");

        $display("[TB] wait states and abort on slave B");
        applyStimulus(1, 1'b1, 32'h8000_0008, 32'h1111_2222, "wrB8");
        applyStimulus(1, 1'b0, 32'h8000_0008, 32'h0, "rdB8");
        psel    = 3'b010;
        pwrite  = 1'b1;
        paddr   = 32'h8000_0008;
        pwdata  = 32'h5555_AAAA;
        @(posedge hclk);
        #1 penable = 1'b1;
        @(negedge hclk);
        checkOutput("abort/wait1Ready", 32'(preadyB), 32'd0);
        checkOutput("abort/idleAReady", 32'(preadyA), 32'd1);
        checkOutput("abort/idleAErr", 32'(pslverrA), 32'd0);
        @(posedge hclk);
        #1;
        psel    = 3'b000;
        penable = 1'b0;
        @(posedge hclk);
        #1;
        applyStimulus(1, 1'b0, 32'h8000_0008, 32'h0, "rdB8AfterAbort");
        applyStimulus(0, 1'b0, 32'h8000_0008, 32'h0, "rdA8Untouched");

        $display("[TB] back-to-back transfers on slave A");
        applyStimulus(0, 1'b0, 32'h8000_0004, 32'h0, "b2bRd4");
        applyStimulus(0, 1'b0, 32'h8000_0000, 32'h0, "b2bRd0");
        applyStimulus(0, 1'b1, 32'h8000_0008, 32'h0102_0304, "b2bWr8");
        applyStimulus(0, 1'b1, 32'h8000_000C, 32'hA5A5_5A5A, "b2bWrC");
        applyStimulus(0, 1'b0, 32'h8000_0008, 32'h0, "b2bRd8");
        applyStimulus(0, 1'b0, 32'h8000_000C, 32'h0, "b2bRdC");

        $display("[TB] protocol violation on slave A");
        applyStimulus(0, 1'b1, 32'h8000_0010, 32'h0BAD_F00D, "wrA10");
        psel    = 3'b001;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = 32'h8000_0010;
        pwdata  = 32'hFFFF_FFFF;
        @(negedge hclk);
        checkOutput("violation/ready", 32'(preadyA), 32'd1);
        checkOutput("violation/pslverr", 32'(pslverrA), 32'd1);
        @(posedge hclk);
        #1;
        psel    = 3'b000;
        penable = 1'b0;
        applyStimulus(0, 1'b0, 32'h8000_0010, 32'h0, "rdA10AfterViolation");

        $display("[TB] reset during a wait cycle on slave B");
        applyStimulus(1, 1'b1, 32'h8000_0010, 32'h7777_8888, "wrB10");
        psel    = 3'b010;
        pwrite  = 1'b1;
        paddr   = 32'h8000_000C;
        pwdata  = 32'h0000_0077;
        @(posedge hclk);
        #1;
        penable = 1'b1;
        hreset  = 1'b1;
        @(negedge hclk);
        checkOutput("midReset/waitReady", 32'(preadyB), 32'd0);
        @(posedge hclk);
        #1;
        hreset  = 1'b0;
        psel    = 3'b000;
        penable = 1'b0;
        clearModel();
        @(negedge hclk);
        checkOutput("midReset/readyB", 32'(preadyB), 32'd1);
        checkOutput("midReset/prdataB", prdataB, 32'h0);
        checkOutput("midReset/prdataA", prdataA, 32'h0);
        @(posedge hclk);
        #1;
        applyStimulus(1, 1'b0, 32'h8000_0010, 32'h0, "rstRdB10");
        applyStimulus(1, 1'b0, 32'h8000_000C, 32'h0, "rstRdBC");
        applyStimulus(0, 1'b0, 32'h8000_0004, 32'h0, "rstRdA4");
        applyStimulus(0, 1'b0, 32'h8000_0010, 32'h0, "rstRdA10");
        applyStimulus(0, 1'b0, 32'h8000_0000, 32'h0, "rstRdId");

        checkOutput("scoreboard/empty", 32'(sbQueue.size()), 32'd0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB completer (responder) at the far end of the bridge's APB bus.
- Decodes its own psel bit and latches each transfer's address, direction and write data in the setup phase.
- Completes the transfer in the access phase after a configurable number of wait states, with error response for bad addresses.
- Backs a small word-addressed register file whose word 0 is a read-only ID.

Parameters:
SLAVE_IDX, 0, which bit of psel[2:0] selects this slave (0..2)
BASE_ADDR, 32'h8000_0000, byte address of register 0; must be 4-byte aligned
N_REGS, 16, number of 32-bit registers (2..64)
WAIT_STATES, 0, number of pready-low access cycles inserted per transfer (0..15)
ID_VALUE, 32'hA9B0_0001, constant returned by register 0

Ports:
hclk  in  1  clock; all state changes on rising edge
hreset  in  1  reset; one clock (hclk), reset hreset is synchronous and active-high
psel  in  3  slave selects; only psel[SLAVE_IDX] is used
penable  in  1  APB access-phase strobe
pwrite  in  1  1 = write, 0 = read
paddr  in  32  byte address
pwdata  in  32  write data
prdata  out  32  read data, registered
pready  out  1  transfer completes this cycle (combinational from state/counter)
pslverr  out  1  error response, valid only when pready=1 in access phase

Behaviour:
- sel = psel[SLAVE_IDX]. FSM states: IDLE, ACCESS. Internal regs: a_addr, a_write, a_wdata, a_err, wcnt (4 bit).
- Reset (hreset=1 at edge): state=IDLE, wcnt=0, prdata=0, a_err=0, all regs 0, reg0 reads ID_VALUE.
- Reset applied mid-transfer aborts the transfer: no write, state IDLE next cycle.
- Decode error a_err is set when any of the following holds:
  - paddr[1:0] != 0
  - paddr < BASE_ADDR
  - paddr >= BASE_ADDR + 4*N_REGS
  - pwrite=1 and the index is 0 (ID register is read-only)
- Index = (paddr - BASE_ADDR) >> 2.
- IDLE:
  - sel & !penable (setup): latch paddr/pwrite/pwdata, compute a_err, load wcnt=WAIT_STATES.
  - On a read with no error, also load prdata with reg[index] (reg0 -> ID_VALUE); on a read with error, load prdata with 0.
  - Go to ACCESS.
- IDLE outputs: pready=1, pslverr=0.
- IDLE, sel & penable with no prior setup (protocol violation): pready=1, pslverr=1 that cycle, no write, stay IDLE.
- ACCESS, sel & penable & wcnt!=0: pready=0, wcnt decrements.
- ACCESS, sel & penable & wcnt==0: pready=1, pslverr=a_err.
  - If a_write & !a_err, reg[index] <= a_wdata at this edge.
  - Next state IDLE, so a back-to-back setup is accepted on the following cycle. Minimum transfer is 2 cycles (setup + access); latency = 2 + WAIT_STATES.
- ACCESS, !sel: abort; no write, next state IDLE, prdata unchanged.
- ACCESS, sel & !penable: new setup; re-latch as in IDLE, and the old transfer is discarded.
- prdata holds its value until the next read setup; writes never change prdata.
- A write followed by a read of the same register returns the new value: the write commits at the access edge, before the next setup.
- Arithmetic: the address compare is done in 33 bits so BASE_ADDR + 4*N_REGS cannot wrap past 2^32; wcnt never underflows.

Decomposition:
- Package apb_pkg holds:
  - state encoding constants ST_IDLE, ST_ACCESS
  - APB_AW=32, APB_DW=32
  - the default ID constant
  - a function for the error/index decode, shared with other future APB slaves
- Sub-module apb_regfile: N_REGS x 32 storage, one write port (we, widx, wdata) and one combinational read port (ridx, rdata).
  - Index 0 is hard-wired to ID_VALUE.
  - Reset clears the RW entries.
- The FSM, wait counter and decode stay in apb_slave_regfile.

Test Plan:
- Write then read, WAIT_STATES=0:
  - Write 32'hDEAD_BEEF to 32'h8000_0004 -> pready=1, pslverr=0 in access cycle.
  - Then read 32'h8000_0004 -> prdata=32'hDEAD_BEEF in the access cycle, total 2 cycles per transfer.
- Read ID: read 32'h8000_0000 -> prdata=32'hA9B0_0001, pslverr=0. Write 32'h1234 to 32'h8000_0000 -> pslverr=1 and a subsequent read still gives 32'hA9B0_0001.
- Errors: read 32'h8000_0040 (N_REGS=16) and 32'h8000_0006 -> pslverr=1, prdata=0. Write to 32'h7FFF_FFFC -> pslverr=1, no register changed.
- Wait states, WAIT_STATES=3:
  - Write to 32'h8000_0008 -> pready low 3 access cycles, high on the 4th; the write is visible only after the pready=1 edge.
  - Drop psel during the 2nd wait cycle -> no write, the register keeps its old value.
- Back-to-back transfers per the bridge sequence: read, read, write, write (different registers) with no idle cycles -> every transfer completes with the correct data, and psel[1] traffic is ignored when SLAVE_IDX=0.
- Reset and protocol violation:
  - hreset asserted during a wait cycle -> next cycle pready=1, all RW regs read 0.
  - penable=1 with no setup -> pslverr=1 for that cycle, no write.
